// File: rtl/divisor_secuencial_gen.sv
// Sequential restoring divider, signed/unsigned, BITS_POR_CICLO quotient bits per cycle.
// Optional divide-by-zero detection is enabled by defining DIVISOR_DIVCERO_EN.
module divisor_secuencial_gen #(
   parameter int tamanyo        = 32,
   parameter int BITS_POR_CICLO = 1
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               Start,
   input  logic               ConSigno,
   input  logic [tamanyo-1:0] Num,
   input  logic [tamanyo-1:0] Den,
   output logic [tamanyo-1:0] Coc,
   output logic [tamanyo-1:0] Res,
   output logic               Done,
   output logic               Busy,
   output logic               DivCero
);

   localparam int N  = tamanyo / BITS_POR_CICLO;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

   typedef enum logic [2:0] {INICIO, PREPARA, CALCULA, AJUSTA, FIN} estado_t;

   estado_t            st_q;
   logic [tamanyo-1:0] num_q, den_q, rem_q, quo_q, coc_q, res_q;
   logic [tamanyo-1:0] rem_d, quo_d, absNum, absDen;
   logic [tamanyo:0]   shifted, diff;
   logic [CW-1:0]      cnt_q;
   logic               signo_q, negQ_q, negR_q, done_q, busy_q;
`ifdef DIVISOR_DIVCERO_EN
   logic               divCero_q;
`endif

   // Magnitudes stay tamanyo bits wide unsigned, so the most negative value is exact.
   assign absNum = (signo_q && num_q[tamanyo-1]) ? -num_q : num_q;
   assign absDen = (signo_q && den_q[tamanyo-1]) ? -den_q : den_q;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      shifted = '0;
      diff    = '0;
      for (int i = 0; i < BITS_POR_CICLO; i++) begin
         shifted = {rem_d, quo_d[tamanyo-1]};
         diff    = shifted - {1'b0, den_q};
         if (shifted >= {1'b0, den_q}) begin
            rem_d = diff[tamanyo-1:0];
            quo_d = {quo_d[tamanyo-2:0], 1'b1};
         end else begin
            rem_d = shifted[tamanyo-1:0];
            quo_d = {quo_d[tamanyo-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge CLK or posedge RSTa) begin
      if (RSTa) begin
         st_q    <= INICIO;
         num_q   <= '0;
         den_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         coc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         signo_q <= 1'b0;
         negQ_q  <= 1'b0;
         negR_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef DIVISOR_DIVCERO_EN
         divCero_q <= 1'b0;
`endif
      end else begin
         case (st_q)
            INICIO: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               if (Start) begin
                  num_q   <= Num;
                  den_q   <= Den;
                  signo_q <= ConSigno;
                  busy_q  <= 1'b1;
                  st_q    <= PREPARA;
`ifdef DIVISOR_DIVCERO_EN
                  divCero_q <= 1'b0;
`endif
               end
            end
            PREPARA: begin
               quo_q  <= absNum;
               den_q  <= absDen;
               rem_q  <= '0;
               cnt_q  <= '0;
               negQ_q <= signo_q & (num_q[tamanyo-1] ^ den_q[tamanyo-1]);
               negR_q <= signo_q & num_q[tamanyo-1];
               st_q   <= CALCULA;
`ifdef DIVISOR_DIVCERO_EN
               // Zero divisor bypasses the iteration; Done then rises on the following edge in FIN.
               if (den_q == '0) begin
                  divCero_q <= 1'b1;
                  coc_q     <= '1;
                  res_q     <= num_q;
                  busy_q    <= 1'b0;
                  st_q      <= FIN;
               end
`endif
            end
            CALCULA: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == ULTIMO) st_q <= AJUSTA;
            end
            AJUSTA: begin
               coc_q  <= negQ_q ? -quo_q : quo_q;
               res_q  <= negR_q ? -rem_q : rem_q;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               st_q   <= FIN;
            end
            FIN: begin
               done_q <= 1'b1;
               if (!Start) begin
                  done_q <= 1'b0;
                  st_q   <= INICIO;
               end
            end
            default: st_q <= INICIO;
         endcase
      end
   end

   assign Coc  = coc_q;
   assign Res  = res_q;
   assign Done = done_q;
   assign Busy = busy_q;
`ifdef DIVISOR_DIVCERO_EN
   assign DivCero = divCero_q;
`else
   assign DivCero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_secuencial_gen.sv
// Self-checking bench for divisor_secuencial_gen: one instance at 1 bit/cycle, one at 4 bits/cycle.
// Expected results come from a behavioural model pushed to a scoreboard queue.
module tb_divisor_secuencial_gen;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] coc;
      logic [W-1:0] res;
      int           lat;
      int           busyCyc;
      logic         divc;
   } expect_t;

   logic         CLK = 1'b0;
   logic         RSTa = 1'b1;
   logic         start1 = 1'b0, start4 = 1'b0;
   logic         ConSigno = 1'b0;
   logic [W-1:0] Num = '0, Den = '0;
   logic [W-1:0] coc1, res1, coc4, res4;
   logic         done1, busy1, dz1, done4, busy4, dz4;

   int checks = 0;
   int errors = 0;
   expect_t scoreboard[$];

   divisor_secuencial_gen #(.tamanyo(W), .BITS_POR_CICLO(1)) dut (
      .CLK(CLK), .RSTa(RSTa), .Start(start1), .ConSigno(ConSigno),
      .Num(Num), .Den(Den), .Coc(coc1), .Res(res1),
      .Done(done1), .Busy(busy1), .DivCero(dz1));

   divisor_secuencial_gen #(.tamanyo(W), .BITS_POR_CICLO(4)) dut4 (
      .CLK(CLK), .RSTa(RSTa), .Start(start4), .ConSigno(ConSigno),
      .Num(Num), .Den(Den), .Coc(coc4), .Res(res4),
      .Done(done4), .Busy(busy4), .DivCero(dz4));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Behavioural reference: language division with the signed overflow case made explicit.
   function automatic expect_t model(input logic [W-1:0] n, input logic [W-1:0] d,
                                     input logic s, input bit use4);
      expect_t e;
      logic signed [W-1:0] sn, sd;
      sn = n;
      sd = d;
      e.lat     = (use4 ? W / 4 : W) + 2;
      e.busyCyc = e.lat;
      e.divc    = 1'b0;
`ifdef DIVISOR_DIVCERO_EN
      if (d == '0) begin
         e.coc = '1; e.res = n; e.lat = 2; e.busyCyc = -1; e.divc = 1'b1;
         return e;
      end
`endif
      if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
         e.coc = n; e.res = '0;
      end else if (s) begin
         e.coc = sn / sd; e.res = sn % sd;
      end else begin
         e.coc = n / d; e.res = n % d;
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input bit use4, input int lat,
                              input int busyCnt, input bit timeout);
      expect_t e;
      chk({tag, ".timeout"}, W'(timeout), '0);
      if (scoreboard.size() == 0) begin
         chk({tag, ".scoreboard"}, W'(0), W'(1));
         return;
      end
      e = scoreboard.pop_front();
      chk({tag, ".Coc"}, use4 ? coc4 : coc1, e.coc);
      chk({tag, ".Res"}, use4 ? res4 : res1, e.res);
      chk({tag, ".latency"}, W'(lat), W'(e.lat));
      if (e.busyCyc >= 0) chk({tag, ".busyCycles"}, W'(busyCnt), W'(e.busyCyc));
      chk({tag, ".DivCero"}, W'(use4 ? dz4 : dz1), W'(e.divc));
   endtask

   // Drives one operation; optionally holds Start after Done and corrupts Num mid-run.
   task automatic applyStimulus(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                                input logic s, input bit use4, input int hold, input int chgAt);
      int  cyc = 0, busyCnt = 0, highCnt = 0;
      bit  timeout = 0;
      scoreboard.push_back(model(n, d, s, use4));
      Num = n; Den = d; ConSigno = s;
      if (use4) start4 = 1'b1; else start1 = 1'b1;
      forever begin
         @(negedge CLK);
         cyc++;
         if (cyc == chgAt) begin Num = ~n; Den = d + 1; ConSigno = ~s; end
         if (use4 ? busy4 : busy1) busyCnt++;
         if (use4 ? done4 : done1) break;
         if (cyc > 200) begin timeout = 1; break; end
      end
      checkOutput(tag, use4, cyc - 1, busyCnt, timeout);
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            if (use4 ? done4 : done1) highCnt++;
         end
         chk({tag, ".holdDone"}, W'(highCnt), W'(hold));
      end
      start1 = 1'b0; start4 = 1'b0;
      @(negedge CLK);
      chk({tag, ".doneDrop"}, W'(use4 ? done4 : done1), '0);
   endtask

   initial begin
      $display("[TB] start");
      repeat (2) @(negedge CLK);
      chk("reset.Coc",  coc1, '0);
      chk("reset.Res",  res1, '0);
      chk("reset.Done", W'(done1), '0);
      chk("reset.Busy", W'(busy1), '0);
      chk("reset.DivCero", W'(dz1), '0);
      RSTa = 1'b0;
      @(negedge CLK);

      applyStimulus("u17_3",  32'd17, 32'd3, 1'b0, 0, 0, 0);
      applyStimulus("s15_3",  32'd15, 32'd3, 1'b1, 0, 0, 0);
      applyStimulus("s17_m3", 32'd17, -32'sd3, 1'b1, 0, 0, 0);
      applyStimulus("sm23_m5", -32'sd23, -32'sd5, 1'b1, 0, 0, 0);
      applyStimulus("sm17_3", -32'sd17, 32'd3, 1'b1, 0, 0, 0);
      applyStimulus("sm18_3", -32'sd18, 32'd3, 1'b1, 0, 0, 0);
      applyStimulus("uBig",   32'hFFFF_FFF0, 32'h10, 1'b0, 0, 0, 0);
      applyStimulus("sBig",   32'hFFFF_FFF0, 32'h10, 1'b1, 0, 0, 0);

      applyStimulus("b4_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);
      applyStimulus("b4_100_7", 32'd100, 32'd7, 1'b0, 1, 0, 0);
      applyStimulus("b4_rand", W'($urandom), W'($urandom_range(1, 1000)), 1'b0, 1, 0, 0);

      applyStimulus("hold5",  32'd1000, 32'd33, 1'b0, 0, 5, 0);
      applyStimulus("numChg", 32'd12345, 32'd67, 1'b0, 0, 0, 12);

      // Reset in the middle of an iteration must clear every output asynchronously.
      Num = 32'd100; Den = 32'd7; ConSigno = 1'b0; start1 = 1'b1;
      repeat (10) @(negedge CLK);
      RSTa = 1'b1;
      #1;
      chk("midReset.Coc",  coc1, '0);
      chk("midReset.Res",  res1, '0);
      chk("midReset.Done", W'(done1), '0);
      chk("midReset.Busy", W'(busy1), '0);
      start1 = 1'b0;
      @(negedge CLK);
      RSTa = 1'b0;
      @(negedge CLK);
      applyStimulus("afterReset", -32'sd99, 32'd10, 1'b1, 0, 0, 0);

`ifdef DIVISOR_DIVCERO_EN
      applyStimulus("div0", 32'd42, 32'd0, 1'b0, 0, 0, 0);
      applyStimulus("after0", 32'd9, 32'd3, 1'b0, 0, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
